// File: rtl/tx_fifo.sv
// tx_fifo: transmit-side byte buffer between the bridge core and the UART transmitter.
// Bytes written on wr_en are queued in a DEPTH-entry array and then moved into a
// registered output stage, so tx_data/tx_valid come straight from flops.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous active-high reset
//   wr_en     - write strobe, one byte per cycle
//   wr_data   - byte to enqueue
//   full      - storage array holds DEPTH entries (output register not counted)
//   free      - empty storage entries, 0..DEPTH
//   tx_data   - byte offered to the transmitter
//   tx_valid  - tx_data is valid
//   tx_ready  - transmitter accepts tx_data this cycle
//   idle      - storage empty and output stage empty
//   ovf_clr   - (TX_FIFO_OVF_EN) synchronous clear of ovf/ovf_count
//   ovf       - (TX_FIFO_OVF_EN) sticky flag: a write was dropped while full
//   ovf_count - (TX_FIFO_OVF_EN) saturating count of dropped bytes
//
// Optional feature: define TX_FIFO_OVF_EN to add the overflow flag and counter.
// Without it, writes while full are dropped with no trace.

module tx_fifo #(
  parameter int unsigned DEPTH = 256,
  localparam int unsigned ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [7:0]           wr_data,
  output logic                 full,
  output logic [ADDR_BITS:0]   free,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
`ifdef TX_FIFO_OVF_EN
  input  logic                 ovf_clr,
  output logic                 ovf,
  output logic [15:0]          ovf_count,
`endif
  output logic                 idle
);

  localparam logic [ADDR_BITS:0] DepthP = (ADDR_BITS + 1)'(DEPTH);

  logic [7:0]         mem [DEPTH];
  logic [ADDR_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               mem_empty;
  logic               do_write;
  logic               load;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign mem_empty = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[ADDR_BITS-1:0] == rd_ptr_q[ADDR_BITS-1:0]) &&
                     (wr_ptr_q[ADDR_BITS] != rd_ptr_q[ADDR_BITS]);
  assign free      = DepthP - (wr_ptr_q - rd_ptr_q);

  // full is the pre-edge value, so a write while full is dropped even if a
  // load frees an entry in the same cycle.
  assign do_write  = wr_en && !full;
  assign load      = !mem_empty && (!tx_valid_q || tx_ready);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (do_write) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (load) begin
      tx_data_d  = mem[rd_ptr_q[ADDR_BITS-1:0]];
      tx_valid_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + 1'b1;
    end else if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_q[ADDR_BITS-1:0]] <= wr_data;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign idle     = mem_empty && !tx_valid_q;

`ifdef TX_FIFO_OVF_EN
  logic        ovf_q, ovf_d;
  logic [15:0] ovf_count_q, ovf_count_d;

  // Clear is applied first so a drop in the same cycle wins.
  always_comb begin
    ovf_d       = ovf_q;
    ovf_count_d = ovf_count_q;
    if (ovf_clr) begin
      ovf_d       = 1'b0;
      ovf_count_d = 16'h0000;
    end
    if (wr_en && full) begin
      ovf_d = 1'b1;
      if (ovf_count_d != 16'hFFFF) begin
        ovf_count_d = ovf_count_d + 16'h0001;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q       <= 1'b0;
      ovf_count_q <= 16'h0000;
    end else begin
      ovf_q       <= ovf_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign ovf       = ovf_q;
  assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_tx_fifo.sv
// Self-checking bench for tx_fifo (DEPTH=4) against a queue-based reference model.
module tb_tx_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AB    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic [AB:0]   free;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          idle;
`ifdef TX_FIFO_OVF_EN
  logic          ovf_clr;
  logic          ovf;
  logic [15:0]   ovf_count;
`endif

  tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .free     (free),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
`ifdef TX_FIFO_OVF_EN
    .ovf_clr  (ovf_clr),
    .ovf      (ovf),
    .ovf_count(ovf_count),
`endif
    .idle     (idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: storage as a queue plus one output register.
  logic [7:0]  m_mem[$];
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ovf;
  logic [15:0] m_cnt;
  logic [7:0]  exp_q[$];   // accepted writes, in order
  logic [7:0]  got_q[$];   // bytes the DUT handed over

  function automatic void model_reset();
    m_mem.delete();
    exp_q.delete();
    got_q.delete();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ovf   = 1'b0;
    m_cnt   = 16'h0000;
  endfunction

  function automatic void model_step(logic we, logic [7:0] wd, logic rdy, logic clr);
    logic full_pre;
    full_pre = (m_mem.size() == DEPTH);
    if (m_mem.size() > 0 && (!m_valid || rdy)) begin
      m_data  = m_mem.pop_front();
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (we && !full_pre) begin
      m_mem.push_back(wd);
      exp_q.push_back(wd);
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_cnt = 16'h0000;
    end
    if (we && full_pre) begin
      m_ovf = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
    end
  endfunction

  task automatic compare_all();
    check("tx_valid", 32'(tx_valid), 32'(m_valid));
    if (m_valid) check("tx_data", 32'(tx_data), 32'(m_data));
    check("full", 32'(full), 32'(m_mem.size() == DEPTH));
    check("free", 32'(free), 32'(DEPTH - m_mem.size()));
    check("idle", 32'(idle), 32'(m_mem.size() == 0 && !m_valid));
`ifdef TX_FIFO_OVF_EN
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("ovf_count", 32'(ovf_count), 32'(m_cnt));
`endif
  endtask

  // One clock: drive inputs, log a handshake, step model on the edge, compare #1 later.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic rdy,
                       input logic clr = 1'b0);
    wr_en    = we;
    wr_data  = wd;
    tx_ready = rdy;
`ifdef TX_FIFO_OVF_EN
    ovf_clr  = clr;
`endif
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    @(posedge clk);
    model_step(we, wd, rdy, clr);
    #1;
    compare_all();
  endtask

  // Compare handed-over bytes against accepted writes, in order.
  task automatic check_order(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH + 4; i++) cycle(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    tx_ready = 1'b0;
`ifdef TX_FIFO_OVF_EN
    ovf_clr  = 1'b0;
`endif
    model_reset();
    #12;
    check("rst_free", 32'(free), DEPTH);
    check("rst_full", 32'(full), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single byte with tx_ready held high.
    cycle(1'b1, 8'hA5, 1'b1);
    check("single_lat0_valid", 32'(tx_valid), 0);
    cycle(1'b0, 8'h00, 1'b1);
    check("single_valid", 32'(tx_valid), 1);
    check("single_data", 32'(tx_data), 32'h A5);
    cycle(1'b0, 8'h00, 1'b1);
    check("single_idle", 32'(idle), 1);
    check_order("single_order");

    // Fill under backpressure; sixth byte is dropped.
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      if (i == 5) begin
        check("fill_full", 32'(full), 1);
        check("fill_free", 32'(free), 0);
      end
      if (i >= 2) check("fill_hold", 32'(tx_data), 32'h01);
    end
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      check("drain_seq", 32'(tx_data), 32'(i == 5 ? 5 : i + 1));
    end
    drain();
    check_order("fill_order");

    // Streaming 20 bytes through pointer wrap with random tx_ready.
    begin
      int n = 0;
      while (n < 20) begin
        if (m_mem.size() < DEPTH) begin
          cycle(1'b1, 8'(8'h10 + n), 1'($urandom_range(0, 1)));
          n++;
        end else begin
          cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)));
        end
      end
    end
    drain();
    check("stream_exp_len", 32'(exp_q.size()), 20);
    for (int i = 0; i < 20 && i < exp_q.size(); i++) check("stream_ref", 32'(exp_q[i]), 32'(8'h10 + i));
    check_order("stream_order");

    // Simultaneous write and load with free=2.
    cycle(1'b1, 8'h31, 1'b0);
    cycle(1'b1, 8'h32, 1'b0);
    cycle(1'b1, 8'h33, 1'b0);
    check("sim_pre_free", 32'(free), 2);
    cycle(1'b1, 8'h34, 1'b1);
    check("sim_free", 32'(free), 2);
    drain();
    check_order("sim_order");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    drain();
    check_order("rand_order");

`ifdef TX_FIFO_OVF_EN
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 1'b0);
    check("ovf_set", 32'(ovf), 1);
    check("ovf_cnt3", 32'(ovf_count), 3);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr", 32'(ovf), 0);
    check("ovf_clr_cnt", 32'(ovf_count), 0);
    cycle(1'b1, 8'hEF, 1'b0, 1'b1);
    check("ovf_set_wins", 32'(ovf), 1);
    check("ovf_set_wins_cnt", 32'(ovf_count), 1);
    drain();
    check_order("ovf_order");
`endif

    // Reset asserted mid-transfer: tx_valid falls without a clock edge.
    cycle(1'b1, 8'h77, 1'b0);
    cycle(1'b1, 8'h78, 1'b0);
    check("pre_rst_valid", 32'(tx_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(tx_valid), 0);
    check("async_rst_idle", 32'(idle), 1);
    check("async_rst_free", 32'(free), DEPTH);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(1'b1, 8'h99, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    check("post_rst_data", 32'(tx_data), 32'h99);
    drain();
    check_order("post_rst_order");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_fifo.md
Name: tx_fifo

Overview:
- Transmit-side byte buffer for the UART/JTAG bridge.
- Accepts bytes from the bridge core on a write-enable interface and presents them to the UART transmitter on a valid/ready stream.
- Mirror of the receive-side buffer.
- Self-contained: own storage array, read/write pointers and a registered output stage, so tx_data/tx_valid come straight from flops.

Parameters:
- DEPTH, 256: number of storage entries; power of two, >= 2.
- ADDR_BITS, $clog2(DEPTH): localparam; pointer index width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe from bridge core; one byte per cycle.
- wr_data  input  8  byte to enqueue.
- full  output  1  storage array holds DEPTH entries.
- free  output  ADDR_BITS+1  empty storage entries, 0..DEPTH.
- tx_data  output  8  byte offered to UART transmitter.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  transmitter accepts tx_data this cycle.
- idle  output  1  storage empty AND tx_valid low.

Behaviour:
- Reset (async assert, release sync to clk):
  - wr_ptr = rd_ptr = 0; tx_valid = 0; tx_data = 8'h00.
  - full = 0, free = DEPTH, idle = 1.
  - Storage contents not reset.
- Pointers:
  - ADDR_BITS+1 bits wide; low bits index the array, MSB is the wrap bit.
  - mem_empty when pointers are equal.
  - full when low bits match and MSBs differ.
  - free = DEPTH - (wr_ptr - rd_ptr), modulo 2^(ADDR_BITS+1).
  - full and free are combinational from the pointers.
- Write:
  - wr_en && !full: mem[wr_ptr] <= wr_data, wr_ptr increments.
  - wr_en while full: byte dropped silently, no state change (unless TX_FIFO_OVF_EN).
- Output stage:
  - load = !mem_empty && (!tx_valid || tx_ready).
  - On load: tx_data <= mem[rd_ptr], rd_ptr increments, tx_valid <= 1.
  - tx_valid && tx_ready && mem_empty: tx_valid <= 0.
  - tx_valid && !tx_ready: tx_data and tx_valid hold; tx_data must not change while tx_valid is high and unaccepted.
- Throughput and latency:
  - One byte per cycle when tx_ready is held high.
  - Byte written at edge k: tx_valid high after edge k+1 if the stage was empty. No write-to-output bypass.
- Capacity:
  - full/free describe the storage array only; the output register holds one extra byte, so total capacity is DEPTH+1.
- Simultaneous write and load:
  - Both pointers advance; free unchanged.
  - A write while full is still dropped even if a load frees an entry that cycle, because full is sampled before the edge.
- Wrap-around: pointers roll over naturally; ordering is preserved across the wrap.
- Reset mid-transfer: tx_valid drops immediately on rst assertion; the pending byte is lost.
- idle = mem_empty && !tx_valid; the bridge uses it to know the TX path is drained.

Optional Feature:
- Macro: TX_FIFO_OVF_EN.
- Defined, adds two outputs:
  - ovf (1 bit, sticky): set on the edge where wr_en && full; cleared only by rst or by input ovf_clr (1 bit, synchronous, one-cycle pulse). If a set and a clear occur in the same cycle, set wins.
  - ovf_count (16 bits): increments per dropped byte, saturates at 16'hFFFF, cleared with ovf.
- Not defined: ovf, ovf_clr and ovf_count do not exist; dropped writes leave no trace.

Test Plan:
- Reset then idle, DEPTH=4:
  - Required: free=4, full=0, idle=1, tx_valid=0.
  - Assert rst mid-stream: tx_valid falls in the same cycle, without waiting for a clock edge.
- Single byte, tx_ready=1:
  - Stimulus: write 8'hA5 at edge k.
  - Required: tx_valid=1 and tx_data=8'hA5 after edge k+1; accepted at edge k+2; idle=1 afterwards.
- Fill and backpressure, tx_ready=0:
  - Stimulus: write 8'h01..8'h06 on consecutive cycles.
  - Required: tx_data=8'h01 held stable; full=1 and free=0 after the 5th write; 8'h06 dropped.
  - Then tx_ready=1: bytes 8'h01..8'h05 emerge one per cycle, in order.
- Streaming through wrap:
  - Stimulus: write 20 bytes 8'h10+i while tx_ready toggles pseudo-randomly.
  - Required: output sequence matches exactly, with no duplicates and no gaps across pointer wrap.
- Simultaneous write and read with free=2:
  - Stimulus: wr_en and load in the same cycle.
  - Required: free stays 2 and both bytes keep their order.
- TX_FIFO_OVF_EN:
  - Stimulus: three writes while full.
  - Required: ovf=1 and ovf_count=3; after an ovf_clr pulse both are 0; with ovf_clr and an overflow in the same cycle, ovf=1 and ovf_count=1.
